// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator for RGB444 pixels, readClk domain.
// Optional WINDOW_COORD_EN adds outX/outY centre-coordinate outputs.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic        readClk,
  input  logic        reset,
  input  logic        frameStart,
  input  logic        pixValid,
  input  logic [11:0] pixIn,
  output logic        winValid,
  output logic [11:0] outPixel_lu,
  output logic [11:0] outPixel_lm,
  output logic [11:0] outPixel_ld,
  output logic [11:0] outPixel_mu,
  output logic [11:0] outPixel_mm,
  output logic [11:0] outPixel_md,
  output logic [11:0] outPixel_ru,
  output logic [11:0] outPixel_rm,
  output logic [11:0] outPixel_rd
`ifdef WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  outX,
  output logic [$clog2(IMG_HEIGHT)-1:0] outY
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col, x;
  logic [RW-1:0] row, y;
  logic          accept, lastCol, qualify;

  logic [11:0] lbOld [IMG_WIDTH];
  logic [11:0] lbNew [IMG_WIDTH];

  // win[column][row]: column 0=l,1=m,2=r; row 0=u,1=m,2=d
  logic [2:0][2:0][11:0] win;

  // A frameStart beat is treated as pixel (0,0) regardless of the counters.
  always_comb begin
    accept  = pixValid && (frameStart || state == FILL || state == RUN);
    x       = frameStart ? '0 : col;
    y       = frameStart ? '0 : row;
    lastCol = (x == CW'(IMG_WIDTH - 1));
    qualify = !frameStart && (x >= CW'(2)) && (y >= RW'(2));
  end

  always_ff @(posedge readClk) begin
    if (accept) begin
      lbOld[x] <= lbNew[x];
      lbNew[x] <= pixIn;
    end
  end

  always_ff @(posedge readClk) begin
    if (reset) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      winValid <= 1'b0;
      win      <= '0;
`ifdef WINDOW_COORD_EN
      outX     <= '0;
      outY     <= '0;
`endif
    end else begin
      winValid <= 1'b0;
      if (accept) begin
        win[0]   <= win[1];
        win[1]   <= win[2];
        win[2]   <= {pixIn, lbNew[x], lbOld[x]};
        winValid <= qualify;
`ifdef WINDOW_COORD_EN
        if (qualify) begin
          outX <= x - 1'b1;
          outY <= y - 1'b1;
        end
`endif
        if (frameStart) state <= FILL;
        if (lastCol) begin
          col <= '0;
          if (!frameStart && state == RUN && y == RW'(IMG_HEIGHT - 1)) begin
            state <= DONE;
          end else begin
            row <= y + 1'b1;
            if (!frameStart && state == FILL && y == RW'(1)) state <= RUN;
          end
        end else begin
          col <= x + 1'b1;
          row <= y;
        end
      end
    end
  end

  assign outPixel_lu = win[0][0];
  assign outPixel_lm = win[0][1];
  assign outPixel_ld = win[0][2];
  assign outPixel_mu = win[1][0];
  assign outPixel_mm = win[1][1];
  assign outPixel_md = win[1][2];
  assign outPixel_ru = win[2][0];
  assign outPixel_rm = win[2][1];
  assign outPixel_rd = win[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen with an 8x6 image and p(x,y)={y,x,A}.
module tb_window_3x3_gen;
  localparam int W = 8;
  localparam int H = 6;

  logic        readClk = 1'b0;
  logic        reset = 1'b0, frameStart = 1'b0, pixValid = 1'b0;
  logic [11:0] pixIn = '0;
  logic        winValid;
  logic [11:0] lu, lm, ld, mu, mm, md, ru, rm, rd;
`ifdef WINDOW_COORD_EN
  logic [2:0]  outX, outY;
`endif

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .readClk(readClk), .reset(reset), .frameStart(frameStart),
    .pixValid(pixValid), .pixIn(pixIn), .winValid(winValid),
    .outPixel_lu(lu), .outPixel_lm(lm), .outPixel_ld(ld),
    .outPixel_mu(mu), .outPixel_mm(mm), .outPixel_md(md),
    .outPixel_ru(ru), .outPixel_rm(rm), .outPixel_rd(rd)
`ifdef WINDOW_COORD_EN
    , .outX(outX), .outY(outY)
`endif
  );

  always #5 readClk = ~readClk;

  typedef struct {
    logic [107:0] w;
    int cx, cy, beat, frame;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;
  int cyc = 0, beatIdx = 0, frameId = 0, period = 1, pulseCnt = 0;
  bit mActive = 0;
  int mx = 0, my = 0;
  int prevCyc = 0, prevBeat = 0, prevFrame = -1;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] p(int px, int py);
    logic [3:0] xs, ys;
    xs = 4'(px);
    ys = 4'(py);
    return {ys, xs, 4'hA};
  endfunction

  function automatic logic [107:0] winAt(int cx, int cy);
    return {p(cx-1,cy-1), p(cx-1,cy), p(cx-1,cy+1),
            p(cx,cy-1),   p(cx,cy),   p(cx,cy+1),
            p(cx+1,cy-1), p(cx+1,cy), p(cx+1,cy+1)};
  endfunction

  function automatic logic [107:0] dutWin();
    return {lu, lm, ld, mu, mm, md, ru, rm, rd};
  endfunction

  always @(posedge readClk) cyc <= cyc + 1;

  // Output side of the scoreboard
  always @(negedge readClk) begin
    if (winValid === 1'b1) begin
      pulseCnt++;
      if (sb.size() == 0) begin
        chk("unexpectedPulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("window", dutWin(), e.w);
`ifdef WINDOW_COORD_EN
        chk("coord", {outX, outY}, {3'(e.cx), 3'(e.cy)});
`endif
        if (e.frame == prevFrame)
          chk("spacing", cyc - prevCyc, period * (e.beat - prevBeat));
        prevCyc = cyc; prevBeat = e.beat; prevFrame = e.frame;
      end
    end
  end

  task automatic sendBeat(bit fs);
    if (fs) begin mActive = 1; mx = 0; my = 0; frameId++; end
    pixIn = mActive ? p(mx, my) : 12'($urandom);
    frameStart = fs;
    pixValid = 1'b1;
    if (mActive) begin
      if (mx >= 2 && my >= 2) begin
        exp_t e;
        e.w = winAt(mx-1, my-1); e.cx = mx-1; e.cy = my-1;
        e.beat = beatIdx; e.frame = frameId;
        sb.push_back(e);
      end
      if (mx == W-1) begin
        mx = 0;
        if (my == H-1) mActive = 0; else my++;
      end else mx++;
    end
    beatIdx++;
    @(posedge readClk); #1;
    pixValid = 1'b0; frameStart = 1'b0;
    repeat (period-1) begin @(posedge readClk); #1; end
  endtask

  task automatic sendBeats(int n, bit startFrame);
    for (int i = 0; i < n; i++) sendBeat(startFrame && i == 0);
  endtask

  task automatic drain();
    repeat (2) begin @(posedge readClk); #1; end
    chk("sbEmpty", sb.size(), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge readClk); #1;
    reset = 1'b0;
    mActive = 0;
    chk("rstValid", winValid, 0);
    chk("rstWin", dutWin(), 0);
`ifdef WINDOW_COORD_EN
    chk("rstCoord", {outX, outY}, 0);
`endif
  endtask

  initial begin
    logic [107:0] held;
    @(posedge readClk); #1;
    doReset();

    // continuous frame
    pulseCnt = 0;
    sendBeats(W*H, 1);
    drain();
    chk("pulses", pulseCnt, 24);
    chk("lastMm", mm, 12'h46A);

    // sparse frame
    period = 3; pulseCnt = 0;
    sendBeats(W*H, 1);
    drain();
    chk("pulsesGap", pulseCnt, 24);
    period = 1;

    // reset in row 3, then stray beats, then a clean frame
    sendBeats(3*W + 4, 1);
    drain();
    doReset();
    pulseCnt = 0;
    sendBeats(12, 0);
    drain();
    chk("noPulseAfterRst", pulseCnt, 0);
    sendBeats(W*H, 1);
    drain();
    chk("pulsesPostRst", pulseCnt, 24);

    // restart mid-frame at (4,3)
    sendBeats(3*W + 4, 1);
    drain();
    pulseCnt = 0;
    sendBeats(W*H, 1);
    drain();
    chk("pulsesRestart", pulseCnt, 24);

    // beats past frame end are ignored
    held = dutWin();
    pulseCnt = 0;
    sendBeats(10, 0);
    drain();
    chk("noPulseDone", pulseCnt, 0);
    chk("holdDone", dutWin(), held);
    sendBeats(W*H, 1);
    drain();
    chk("pulsesAfterDone", pulseCnt, 24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
